// File: rtl/full_adder_16bit_pkg.sv
// Shared helpers for the full_adder_16bit slice.
//   signed_overflow : two's-complement overflow from the carries into and
//                     out of the most significant bit position.
package full_adder_16bit_pkg;

  // Signed overflow is the disagreement between the carry entering the MSB
  // and the carry leaving it. It equals the sign-rule form
  // (a[msb]==b[msb] && sum[msb]!=a[msb]).
  function automatic logic signed_overflow(input logic carry_into_msb,
                                           input logic carry_out_msb);
    return carry_into_msb ^ carry_out_msb;
  endfunction

endpackage

// File: rtl/full_adder_1bit.sv
// One-bit full-adder cell, purely combinational.
//   a, b : operand bits
//   cin  : carry into this bit position
//   sum  : a ^ b ^ cin
//   cout : carry out, (a & b) | (cin & (a ^ b))
module full_adder_1bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic half;

  always_comb begin
    half = a ^ b;
    sum  = half ^ cin;
    cout = (a & b) | (cin & half);
  end

endmodule

// File: rtl/full_adder_16bit.sv
// Registered ripple-carry adder, {cout,sum} = a + b + cin.
//   clk      : rising-edge clock for all state
//   rst_n    : synchronous active-low reset; clears sum, cout, overflow
//   a, b     : WIDTH-bit operands (unsigned or two's-complement)
//   cin      : carry-in
//   sum      : registered low WIDTH bits of the result
//   cout     : registered unsigned carry-out (bit WIDTH of the result)
//   overflow : registered two's-complement signed overflow flag
// Latency is one cycle, and a new operation is accepted every cycle.
module full_adder_16bit
  import full_adder_16bit_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  // carry[i] enters bit i; carry[WIDTH] is the unsigned carry-out.
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_comb;

  assign carry[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    full_adder_1bit u_cell (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (carry[i]),
      .sum  (sum_comb[i]),
      .cout (carry[i+1])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sum      <= '0;
      cout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      sum      <= sum_comb;
      cout     <= carry[WIDTH];
      overflow <= signed_overflow(carry[WIDTH-1], carry[WIDTH]);
    end
  end

endmodule

// File: tb/tb_full_adder_16bit.sv
// Self-checking bench for full_adder_16bit: reset behaviour, directed
// corner cases, and randomized back-to-back traffic compared against an
// arithmetic reference model.
module tb_full_adder_16bit;

  logic        clk;
  logic        rst_n;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic [15:0] sum;
  logic        cout;
  logic        overflow;

  int vectors;
  int miscompares;

  full_adder_16bit #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sum      (sum),
    .cout     (cout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: whole-number arithmetic, unsigned for sum/cout and signed
  // range check for overflow.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic c);
    int unsigned u;
    int          s;
    logic [17:0] r;
    u = 32'(x) + 32'(y) + 32'(c);
    s = int'($signed(x)) + int'($signed(y)) + int'(c);
    r[17:2] = u[15:0];
    r[1]    = u[16];
    r[0]    = (s > 32767) || (s < -32768);
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    a = 16'h1234; b = 16'h1111; cin = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if ({sum, cout, overflow} !== 18'h0) begin
      miscompares++;
      $display("FAIL reset: got sum=%h cout=%b ovf=%b, want 0000 0 0", sum, cout, overflow);
    end
  endtask

  task automatic test_first_valid();
    rst_n = 1'b1;
    a = 16'h0005; b = 16'h000A; cin = 1'b0;
    @(negedge clk);
    vectors++;
    if ({sum, cout, overflow} !== {16'h000F, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL first_valid: got sum=%h cout=%b ovf=%b, want 000f 0 0", sum, cout, overflow);
    end
  endtask

  task automatic test_directed();
    logic [15:0] ta [8] = '{16'h0005, 16'h0005, 16'h03FF, 16'h7FFF, 16'h8000, 16'hFFFF, 16'hFFFE, 16'hFFFF};
    logic [15:0] tb_ [8] = '{16'h000A, 16'h000A, 16'h0400, 16'h0001, 16'h8000, 16'h0001, 16'hFFFD, 16'hFFFF};
    logic        tc [8] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [15:0] es [8] = '{16'h000F, 16'h0010, 16'h07FF, 16'h8000, 16'h0000, 16'h0000, 16'hFFFB, 16'hFFFE};
    logic        ec [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic        eo [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) begin
      a = ta[i]; b = tb_[i]; cin = tc[i];
      @(negedge clk);
      vectors++;
      if ({sum, cout, overflow} !== {es[i], ec[i], eo[i]}) begin
        miscompares++;
        $display("FAIL directed[%0d]: got sum=%h cout=%b ovf=%b, want %h %b %b",
                 i, sum, cout, overflow, es[i], ec[i], eo[i]);
      end
    end
    // a+b=0xFFFF with cin=1 wraps to zero with carry-out.
    a = 16'hA5A5; b = 16'h5A5A; cin = 1'b1;
    @(negedge clk);
    vectors++;
    if ({sum, cout, overflow} !== {16'h0000, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL cin_wrap: got sum=%h cout=%b ovf=%b, want 0000 1 0", sum, cout, overflow);
    end
  endtask

  task automatic test_back_to_back();
    logic [17:0] expq[$];
    logic [17:0] exp_v;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0:       a = 16'h7FFF ^ 16'($urandom_range(0, 3));
        1:       a = 16'h8000 | 16'($urandom_range(0, 3));
        default: a = 16'($urandom);
      endcase
      b   = ($urandom_range(0, 4) == 0) ? ~a : 16'($urandom);
      cin = 1'($urandom);
      expq.push_back(model(a, b, cin));
      @(negedge clk);
      exp_v = expq.pop_front();
      vectors++;
      if ({sum, cout, overflow} !== exp_v) begin
        miscompares++;
        $display("FAIL b2b[%0d]: got sum=%h cout=%b ovf=%b, want %h %b %b",
                 i, sum, cout, overflow, exp_v[17:2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  task automatic test_reset_priority();
    logic [17:0] exp_v;
    a = 16'h7FFF; b = 16'h0001; cin = 1'b1;
    @(negedge clk);
    exp_v = model(16'h7FFF, 16'h0001, 1'b1);
    // Reset asserted between edges must not disturb the outputs.
    rst_n = 1'b0;
    a = 16'hFFFF; b = 16'hFFFF;
    #1;
    vectors++;
    if ({sum, cout, overflow} !== exp_v) begin
      miscompares++;
      $display("FAIL no_async_reset: got sum=%h cout=%b ovf=%b, want %h %b %b",
               sum, cout, overflow, exp_v[17:2], exp_v[1], exp_v[0]);
    end
    @(negedge clk);
    vectors++;
    if ({sum, cout, overflow} !== 18'h0) begin
      miscompares++;
      $display("FAIL reset_priority: got sum=%h cout=%b ovf=%b, want 0000 0 0", sum, cout, overflow);
    end
    rst_n = 1'b1;
    a = 16'h8000; b = 16'h8000; cin = 1'b0;
    @(negedge clk);
    vectors++;
    if ({sum, cout, overflow} !== {16'h0000, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL after_reset: got sum=%h cout=%b ovf=%b, want 0000 1 1", sum, cout, overflow);
    end
    // Outputs hold when inputs change mid-cycle.
    a = 16'h1111; b = 16'h2222;
    #2;
    vectors++;
    if ({sum, cout, overflow} !== {16'h0000, 1'b1, 1'b1}) begin
      miscompares++;
      $display("FAIL hold: got sum=%h cout=%b ovf=%b, want 0000 1 1", sum, cout, overflow);
    end
    @(negedge clk);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n = 1'b0;
    a = '0; b = '0; cin = 1'b0;
    @(negedge clk);
    test_reset();
    test_first_valid();
    test_directed();
    test_back_to_back();
    test_reset_priority();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
